// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: question sequencing, keypad press arbitration, answer
// judging and thermometer scoring for the N-player math quiz.
// Optional build macro PENALTY_EN: a wrong answer also removes one point
// (floor 0) in addition to locking the player out for that question.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// ASK    | question shown, timer running, watching for valid presses
// JUDGE  | one cycle: compare captured key with the answer key
// NEXT   | one cycle: clear lockout/timer, advance question or finish
// DONE   | round over, winner valid, waiting for start
module quiz_round_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int KEYW          = 9,
  parameter int NUM_QUESTIONS = 9,
  parameter int SCORE_MAX     = 5,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 bank_sel,
  input  logic [NUM_PLAYERS*KEYW-1:0]          key_in,
  input  logic [KEYW-1:0]                      exp_key,
  output logic [$clog2(NUM_QUESTIONS)-1:0]     q_idx,
  output logic                                 bank_q,
  output logic [NUM_PLAYERS*SCORE_MAX-1:0]     score,
  output logic [NUM_PLAYERS-1:0]               lockout,
  output logic                                 busy,
  output logic                                 game_over,
  output logic [NUM_PLAYERS-1:0]               winner
);

  localparam int QW = $clog2(NUM_QUESTIONS);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = $clog2(SCORE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ASK   = 3'd1,
    S_JUDGE = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      state, state_nx;
  logic [NUM_PLAYERS*KEYW-1:0] key_q, key_hist;
  logic [NUM_PLAYERS-1:0]      press_vld;
  logic                        press_any;
  logic [PW-1:0]               press_sel;
  logic [KEYW-1:0]             press_key;
  logic [PW-1:0]               cap_sel;
  logic [KEYW-1:0]             cap_key;
  logic [TW-1:0]               timer;
  logic                        timeout;
  logic                        correct;
  logic [NUM_PLAYERS-1:0]      lock_after;
  logic                        all_locked;
  logic                        any_full;
  logic                        last_q;
  logic [CW-1:0]               cnt, best_cnt;
  logic [PW-1:0]               best_idx;
  logic                        tie;
  logic [NUM_PLAYERS-1:0]      win_calc;

  // A press is a fresh one-hot code from a player who is not locked out;
  // a multi-key code or a code that follows a non-zero one never counts.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_press
    logic [KEYW-1:0] kv;
    assign kv = key_q[p*KEYW +: KEYW];
    assign press_vld[p] = (kv != '0) && ((kv & (kv - KEYW'(1))) == '0) &&
                          (key_hist[p*KEYW +: KEYW] == '0) && !lockout[p];
  end

  // Lowest-index pressing player wins; scanning downward leaves it last.
  always_comb begin
    press_sel = '0;
    press_key = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (press_vld[p]) begin
        press_sel = PW'(p);
        press_key = key_q[p*KEYW +: KEYW];
      end
    end
    press_any = |press_vld;
  end

  assign timeout    = (timer == TW'(TIMEOUT_CYC - 1));
  assign correct    = (cap_key == exp_key);
  assign lock_after = lockout | (NUM_PLAYERS'(1) << cap_sel);
  assign all_locked = &lock_after;
  assign last_q     = (q_idx == QW'(NUM_QUESTIONS - 1));

  // Any player whose thermometer is completely filled ends the game.
  always_comb begin
    any_full = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (&score[p*SCORE_MAX +: SCORE_MAX]) any_full = 1'b1;
    end
  end

  // Unique highest point count wins; a shared maximum yields no winner.
  always_comb begin
    win_calc = '0;
    cnt      = '0;
    best_cnt = '0;
    best_idx = '0;
    tie      = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cnt = '0;
      for (int b = 0; b < SCORE_MAX; b++) begin
        cnt = cnt + CW'(score[p*SCORE_MAX + b]);
      end
      if (p == 0 || cnt > best_cnt) begin
        best_cnt = cnt;
        best_idx = PW'(p);
        tie      = 1'b0;
      end else if (cnt == best_cnt) begin
        tie = 1'b1;
      end
    end
    if (!tie) win_calc[best_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_ASK;
      S_ASK: begin
        if (press_any)    state_nx = S_JUDGE;
        else if (timeout) state_nx = S_NEXT;
      end
      S_JUDGE: state_nx = (correct || all_locked) ? S_NEXT : S_ASK;
      S_NEXT:  state_nx = (any_full || last_q) ? S_DONE : S_ASK;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy      = (state == S_ASK) || (state == S_JUDGE) || (state == S_NEXT);
  assign game_over = (state == S_DONE);

  // Keypad history, question/timer bookkeeping, scoring and winner latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      key_hist <= '0;
      q_idx    <= '0;
      bank_q   <= 1'b0;
      score    <= '0;
      lockout  <= '0;
      winner   <= '0;
      timer    <= '0;
      cap_sel  <= '0;
      cap_key  <= '0;
    end else begin
      key_q    <= key_in;
      key_hist <= key_q;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score   <= '0;
            lockout <= '0;
            winner  <= '0;
            q_idx   <= '0;
            bank_q  <= bank_sel;
            timer   <= '0;
          end
        end
        S_ASK: begin
          // Saturating: a question re-entered after a wrong answer at the
          // last timer cycle still times out instead of wrapping.
          if (!timeout) timer <= timer + TW'(1);
          if (press_any) begin
            cap_sel <= press_sel;
            cap_key <= press_key;
          end
        end
        S_JUDGE: begin
          if (!correct) lockout <= lock_after;
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (cap_sel == PW'(p)) begin
              if (correct) begin
                score[p*SCORE_MAX +: SCORE_MAX] <=
                  {score[p*SCORE_MAX +: SCORE_MAX-1], 1'b1};
              end else begin
`ifdef PENALTY_EN
                score[p*SCORE_MAX +: SCORE_MAX] <=
                  {1'b0, score[p*SCORE_MAX+1 +: SCORE_MAX-1]};
`else
                score[p*SCORE_MAX +: SCORE_MAX] <= score[p*SCORE_MAX +: SCORE_MAX];
`endif
              end
            end
          end
        end
        S_NEXT: begin
          lockout <= '0;
          timer   <= '0;
          if (any_full || last_q) winner <= win_calc;
          else                    q_idx  <= q_idx + QW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: a directed vector table, hand-written timeout,
// game-end and reset sequences, then random keypad traffic compared against
// a points-based reference model.
module tb_quiz_round_ctrl;

  localparam int NP = 2;
  localparam int KW = 9;
  localparam int NQ = 9;
  localparam int SM = 5;
  localparam int TO = 16;
  localparam int QW = $clog2(NQ);
`ifdef PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic               clk, rst_n, start, bank_sel;
  logic [NP*KW-1:0]   key_in;
  logic [KW-1:0]      exp_key;
  logic [QW-1:0]      q_idx;
  logic               bank_q, busy, game_over;
  logic [NP*SM-1:0]   score;
  logic [NP-1:0]      lockout, winner;

  quiz_round_ctrl #(
    .NUM_PLAYERS(NP), .KEYW(KW), .NUM_QUESTIONS(NQ), .SCORE_MAX(SM), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel), .key_in(key_in),
    .exp_key(exp_key), .q_idx(q_idx), .bank_q(bank_q), .score(score),
    .lockout(lockout), .busy(busy), .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Question ROM stand-in: answer key depends on bank and question index.
  function automatic logic [KW-1:0] rom(input logic b, input int q);
    int s;
    s = (q + (b ? 3 : 0)) % KW;
    return KW'(1) << s;
  endfunction

  assign exp_key = rom(bank_q, int'(q_idx));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic edge_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SM-1:0] therm(input int n);
    return SM'((1 << n) - 1);
  endfunction

  // ---------------- reference model (points, not thermometers) ----------
  localparam int M_IDLE = 0, M_ASK = 1, M_JUDGE = 2, M_NEXT = 3, M_DONE = 4;
  int            m_stage, m_q, m_time, m_pp;
  int            m_pts[NP];
  logic          m_bank;
  logic [NP-1:0] m_lock, m_win;
  logic [KW-1:0] m_pk;
  logic [KW-1:0] m_kq[NP];
  logic [KW-1:0] m_kh[NP];

  task automatic model_reset();
    m_stage = M_IDLE; m_q = 0; m_time = 0; m_pp = 0; m_bank = 1'b0;
    m_lock = '0; m_win = '0; m_pk = '0;
    for (int i = 0; i < NP; i++) begin
      m_pts[i] = 0; m_kq[i] = '0; m_kh[i] = '0;
    end
  endtask

  task automatic model_step(input logic st, input logic bs, input logic [NP*KW-1:0] kin);
    logic [KW-1:0] ek;
    int p, best, nbest, bidx;
    bit full;
    ek = rom(m_bank, m_q);
    case (m_stage)
      M_IDLE, M_DONE: if (st) begin
        for (int i = 0; i < NP; i++) m_pts[i] = 0;
        m_lock = '0; m_win = '0; m_q = 0; m_bank = bs; m_time = 0; m_stage = M_ASK;
      end
      M_ASK: begin
        p = -1;
        for (int i = NP - 1; i >= 0; i--)
          if ($countones(m_kq[i]) == 1 && m_kh[i] == '0 && !m_lock[i]) p = i;
        if (p >= 0) begin
          m_pp = p; m_pk = m_kq[p]; m_stage = M_JUDGE;
        end else if (m_time == TO - 1) m_stage = M_NEXT;
        if (m_time < TO - 1) m_time++;
      end
      M_JUDGE: begin
        if (m_pk == ek) begin
          if (m_pts[m_pp] < SM) m_pts[m_pp]++;
          m_stage = M_NEXT;
        end else begin
          m_lock[m_pp] = 1'b1;
          if (PEN && m_pts[m_pp] > 0) m_pts[m_pp]--;
          m_stage = (&m_lock) ? M_NEXT : M_ASK;
        end
      end
      M_NEXT: begin
        m_lock = '0; m_time = 0; full = 0;
        for (int i = 0; i < NP; i++) if (m_pts[i] == SM) full = 1;
        if (full || m_q == NQ - 1) begin
          best = -1; nbest = 0; bidx = 0;
          for (int i = 0; i < NP; i++) begin
            if (m_pts[i] > best) begin best = m_pts[i]; bidx = i; nbest = 1; end
            else if (m_pts[i] == best) nbest++;
          end
          m_win = (nbest == 1) ? (NP'(1) << bidx) : '0;
          m_stage = M_DONE;
        end else begin
          m_q++; m_stage = M_ASK;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < NP; i++) begin
      m_kh[i] = m_kq[i];
      m_kq[i] = kin[i*KW +: KW];
    end
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    logic          st;
    logic          bs;
    logic [KW-1:0] k0;
    logic [KW-1:0] k1;
    int            q;
    logic          bq;
    logic [NP*SM-1:0] sc;
    logic [NP-1:0] lk;
    logic          bz;
  } vec_t;

  localparam logic [KW-1:0] K3 = 9'b000001000;
  localparam logic [KW-1:0] K4 = 9'b000010000;
  localparam logic [KW-1:0] W1 = 9'b000000001;
  localparam logic [KW-1:0] W0 = 9'b000000010;
  localparam logic [NP*SM-1:0] S1 = 10'b00000_00001;
  localparam logic [NP*SM-1:0] S3 = 10'b00000_00011;
  localparam logic [NP*SM-1:0] SP = PEN ? S1 : S3;

  vec_t tbl[15];

  initial begin
    int pts0, qe;
    logic [KW-1:0] cur[NP];
    int r, a;

    tbl[0]  = '{1'b1, 1'b1, '0, '0, 0, 1'b1, '0, 2'b00, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, K3, '0, 0, 1'b1, '0, 2'b00, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, K3, '0, 0, 1'b1, '0, 2'b00, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, K3, '0, 0, 1'b1, S1, 2'b00, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, '0, '0, 1, 1'b1, S1, 2'b00, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, K4, K4, 1, 1'b1, S1, 2'b00, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, K4, K4, 1, 1'b1, S1, 2'b00, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, K4, K4, 1, 1'b1, S3, 2'b00, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, '0, '0, 2, 1'b1, S3, 2'b00, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, '0, W1, 2, 1'b1, S3, 2'b00, 1'b1};
    tbl[10] = '{1'b0, 1'b0, '0, '0, 2, 1'b1, S3, 2'b00, 1'b1};
    tbl[11] = '{1'b0, 1'b0, W0, '0, 2, 1'b1, S3, 2'b10, 1'b1};
    tbl[12] = '{1'b0, 1'b0, W0, '0, 2, 1'b1, S3, 2'b10, 1'b1};
    tbl[13] = '{1'b0, 1'b0, '0, '0, 2, 1'b1, SP, 2'b11, 1'b1};
    tbl[14] = '{1'b0, 1'b0, '0, '0, 3, 1'b1, SP, 2'b00, 1'b1};

    rst_n = 1'b0; start = 1'b0; bank_sel = 1'b0; key_in = '0;
    #12;
    chk("rst_q_idx", q_idx, 0);
    chk("rst_bank_q", bank_q, 0);
    chk("rst_score", score, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start = tbl[i].st; bank_sel = tbl[i].bs; key_in = {tbl[i].k1, tbl[i].k0};
      edge_clk();
      chk($sformatf("tbl%0d_q_idx", i), q_idx, tbl[i].q);
      chk($sformatf("tbl%0d_bank_q", i), bank_q, tbl[i].bq);
      chk($sformatf("tbl%0d_score", i), score, tbl[i].sc);
      chk($sformatf("tbl%0d_lockout", i), lockout, tbl[i].lk);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("tbl%0d_game_over", i), game_over, 0);
    end

    // Timeout on question 3 while keypads show only two-hot or held codes.
    for (int i = 0; i < TO; i++) begin
      key_in = {9'b000110000, (i < 4) ? 9'b000000011 : 9'b000000001};
      edge_clk();
      chk("to_wait_q_idx", q_idx, 3);
      chk("to_wait_busy", busy, 1);
    end
    key_in = '0;
    edge_clk();
    chk("to_q_idx", q_idx, 4);
    chk("to_score", score, SP);
    chk("to_lockout", lockout, 0);

    // Player 0 answers correctly until its thermometer is full.
    pts0 = PEN ? 1 : 2;
    qe = 4;
    while (pts0 < SM) begin
      key_in = {9'b0, rom(1'b1, qe)};
      edge_clk(); edge_clk();
      key_in = '0;
      edge_clk();
      pts0++;
      chk("end_score_p0", score[SM-1:0], therm(pts0));
      edge_clk();
      if (pts0 < SM) begin
        qe++;
        chk("end_q_idx_step", q_idx, qe);
      end
    end
    chk("end_game_over", game_over, 1);
    chk("end_busy", busy, 0);
    chk("end_winner", winner, 2'b01);
    chk("end_q_idx", q_idx, qe);
    chk("end_score_p1", score[NP*SM-1:SM], 0);

    // Restart from DONE, then an asynchronous reset mid-question.
    start = 1'b1; bank_sel = 1'b0;
    edge_clk();
    start = 1'b0;
    chk("restart_q_idx", q_idx, 0);
    chk("restart_bank_q", bank_q, 0);
    chk("restart_score", score, 0);
    chk("restart_winner", winner, 0);
    chk("restart_busy", busy, 1);
    key_in = {9'b0, 9'b000000100};
    edge_clk(); edge_clk();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_q_idx", q_idx, 0);
    chk("arst_score", score, 0);
    chk("arst_lockout", lockout, 0);
    chk("arst_game_over", game_over, 0);
    key_in = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random keypad traffic against the reference model.
    model_reset();
    for (int i = 0; i < NP; i++) cur[i] = '0;
    for (int c = 0; c < 2500; c++) begin
      start = ($urandom_range(0, 59) == 0);
      bank_sel = 1'($urandom_range(0, 1));
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(0, 9);
        if (r >= 6 && r <= 7) cur[p] = '0;
        else if (r == 8) begin
          if ($urandom_range(0, 1) == 1) cur[p] = rom(m_bank, m_q);
          else cur[p] = KW'(1) << $urandom_range(0, KW - 1);
        end else if (r == 9) begin
          a = $urandom_range(0, KW - 1);
          cur[p] = (KW'(1) << a) | (KW'(1) << ((a + 1) % KW));
        end
        key_in[p*KW +: KW] = cur[p];
      end
      model_step(start, bank_sel, key_in);
      edge_clk();
      chk("rnd_q_idx", q_idx, m_q);
      chk("rnd_bank_q", bank_q, m_bank);
      for (int p = 0; p < NP; p++)
        chk($sformatf("rnd_score_p%0d", p), score[p*SM +: SM], therm(m_pts[p]));
      chk("rnd_lockout", lockout, m_lock);
      chk("rnd_busy", busy, (m_stage == M_ASK || m_stage == M_JUDGE || m_stage == M_NEXT));
      chk("rnd_game_over", game_over, (m_stage == M_DONE));
      chk("rnd_winner", winner, m_win);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
